// File: rtl/midi_decoder_pkg.sv
// Shared MIDI types: note event record, message-type codes and decoder FSM states.
package MIDI;

  localparam int unsigned DATA_WIDTH = 7;

  localparam logic [3:0] NOTE_OFF       = 4'h8;
  localparam logic [3:0] NOTE_ON        = 4'h9;
  localparam logic [3:0] CONTROL_CHANGE = 4'hB;

  typedef enum logic {
    OFF = 1'b0,
    ON  = 1'b1
  } note_status_t;

  typedef struct packed {
    note_status_t            status;
    logic [DATA_WIDTH-1:0]   note_number;
    logic [DATA_WIDTH-1:0]   velocity;
  } note_change_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DATA1 = 2'd1,
    DATA2 = 2'd2,
    SKIP  = 2'd3
  } midi_decode_state_t;

endpackage

// File: rtl/midi_decoder.sv
// MIDI byte-stream decoder: note on/off and control-change events with running status,
// channel filtering and real-time byte pass-over.
module midi_decoder
  import MIDI::*;
#(
  parameter int unsigned CHANNEL = 0,
  parameter int unsigned OMNI    = 0
) (
  input  logic                  clock_50_000_000,
  input  logic                  reset,
  input  logic [7:0]            byte_data,
  input  logic                  byte_valid,
  output note_change_t          note,
  output logic                  note_ready,
  output logic [DATA_WIDTH-1:0] cc_number,
  output logic [DATA_WIDTH-1:0] cc_value,
  output logic                  cc_ready
);

  midi_decode_state_t    state_q, state_d;
  logic [3:0]            msg_type_q, msg_type_d;
  logic [DATA_WIDTH-1:0] d1_q, d1_d;
  note_change_t          note_q, note_d;
  logic                  note_ready_q, note_ready_d;
  logic [DATA_WIDTH-1:0] cc_number_q, cc_number_d;
  logic [DATA_WIDTH-1:0] cc_value_q, cc_value_d;
  logic                  cc_ready_q, cc_ready_d;

  logic                  is_data, is_status, is_syscommon;
  logic                  type_ok, chan_ok;
  logic [DATA_WIDTH-1:0] d2;

  // Byte classification; real-time bytes (0xF8-0xFF) match none of these and fall through.
  always_comb begin
    is_data      = ~byte_data[7];
    is_status    = byte_data[7] && (byte_data[7:4] != 4'hF);
    is_syscommon = (byte_data[7:3] == 5'b11110);
    type_ok      = (byte_data[7:4] == NOTE_OFF) || (byte_data[7:4] == NOTE_ON) ||
                   (byte_data[7:4] == CONTROL_CHANGE);
    chan_ok      = (OMNI != 0) || (byte_data[3:0] == CHANNEL[3:0]);
    d2           = byte_data[DATA_WIDTH-1:0];
  end

  always_comb begin
    state_d      = state_q;
    msg_type_d   = msg_type_q;
    d1_d         = d1_q;
    note_d       = note_q;
    note_ready_d = 1'b0;
    cc_number_d  = cc_number_q;
    cc_value_d   = cc_value_q;
    cc_ready_d   = 1'b0;

    if (byte_valid) begin
      if (is_status) begin
        msg_type_d = byte_data[7:4];
        state_d    = (type_ok && chan_ok) ? DATA1 : SKIP;
      end else if (is_syscommon) begin
        msg_type_d = 4'h0;
        state_d    = (byte_data == 8'hF0) ? SKIP : IDLE;
      end else if (is_data) begin
        case (state_q)
          DATA1: begin
            d1_d    = byte_data[DATA_WIDTH-1:0];
            state_d = DATA2;
          end
          DATA2: begin
            state_d = DATA1;
            case (msg_type_q)
              NOTE_ON: begin
                note_d.status      = (d2 != '0) ? ON : OFF;
                note_d.note_number = d1_q;
                note_d.velocity    = d2;
                note_ready_d       = 1'b1;
              end
              NOTE_OFF: begin
                note_d.status      = OFF;
                note_d.note_number = d1_q;
                note_d.velocity    = d2;
                note_ready_d       = 1'b1;
              end
              CONTROL_CHANGE: begin
                cc_number_d = d1_q;
                cc_value_d  = d2;
                cc_ready_d  = 1'b1;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clock_50_000_000 or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      msg_type_q   <= 4'h0;
      d1_q         <= '0;
      note_q       <= '{status: OFF, note_number: '0, velocity: '0};
      note_ready_q <= 1'b0;
      cc_number_q  <= '0;
      cc_value_q   <= '0;
      cc_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      msg_type_q   <= msg_type_d;
      d1_q         <= d1_d;
      note_q       <= note_d;
      note_ready_q <= note_ready_d;
      cc_number_q  <= cc_number_d;
      cc_value_q   <= cc_value_d;
      cc_ready_q   <= cc_ready_d;
    end
  end

  assign note       = note_q;
  assign note_ready = note_ready_q;
  assign cc_number  = cc_number_q;
  assign cc_value   = cc_value_q;
  assign cc_ready   = cc_ready_q;

endmodule

// File: tb/tb_midi_decoder.sv
// Directed bench for midi_decoder: one channel-0 instance and one OMNI instance on shared stimulus.
module tb_midi_decoder;
  import MIDI::*;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   byte_data;
  logic         byte_valid;

  note_change_t note_a, note_b;
  logic         note_ready_a, note_ready_b, cc_ready_a, cc_ready_b;
  logic [6:0]   cc_number_a, cc_value_a, cc_number_b, cc_value_b;

  int checks = 0;
  int errors = 0;
  int note_cnt_a = 0, note_cnt_b = 0, cc_cnt_a = 0;
  int snap_a, snap_b, snap_cc;

  midi_decoder #(.CHANNEL(0), .OMNI(0)) dut_a (
    .clock_50_000_000(clk), .reset(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .note(note_a), .note_ready(note_ready_a), .cc_number(cc_number_a),
    .cc_value(cc_value_a), .cc_ready(cc_ready_a)
  );

  midi_decoder #(.CHANNEL(5), .OMNI(1)) dut_b (
    .clock_50_000_000(clk), .reset(rst), .byte_data(byte_data), .byte_valid(byte_valid),
    .note(note_b), .note_ready(note_ready_b), .cc_number(cc_number_b),
    .cc_value(cc_value_b), .cc_ready(cc_ready_b)
  );

  always #10 clk = ~clk;

  // Strobe counters; a pulse high during a cycle is counted at the following rising edge.
  always @(posedge clk) begin
    if (note_ready_a) note_cnt_a <= note_cnt_a + 1;
    if (note_ready_b) note_cnt_b <= note_cnt_b + 1;
    if (cc_ready_a)   cc_cnt_a   <= cc_cnt_a + 1;
  end

  function automatic logic [31:0] exp_note(input logic s, input logic [6:0] n,
                                           input logic [6:0] v);
    return {17'd0, s, n, v};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns on the falling edge after the byte was clocked in, when any strobe is visible.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_data  = b;
    byte_valid = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap;
    snap_a  = note_cnt_a;
    snap_b  = note_cnt_b;
    snap_cc = cc_cnt_a;
  endtask

  initial begin
    rst        = 1'b1;
    byte_data  = 8'h00;
    byte_valid = 1'b0;
    idle(3);
    chk("reset_note", 32'(note_a), exp_note(1'b0, 7'h00, 7'h00));
    chk("reset_cc_number", 32'(cc_number_a), 32'(0));
    chk("reset_cc_value", 32'(cc_value_a), 32'(0));
    chk("reset_note_ready", 32'(note_ready_a), 32'(0));
    chk("reset_cc_ready", 32'(cc_ready_a), 32'(0));
    rst = 1'b0;
    idle(2);

    // Basic note on.
    send(8'h90); send(8'h3C);
    chk("on_no_early_strobe", 32'(note_ready_a), 32'(0));
    send(8'h64);
    chk("on_ready", 32'(note_ready_a), 32'(1));
    chk("on_note", 32'(note_a), exp_note(1'b1, 7'h3C, 7'h64));
    chk("on_cc_ready", 32'(cc_ready_a), 32'(0));
    idle(1);
    chk("on_pulse_one_cycle", 32'(note_ready_a), 32'(0));
    chk("on_note_held", 32'(note_a), exp_note(1'b1, 7'h3C, 7'h64));

    // Running status with velocity 0, then explicit note off keeps release velocity.
    send(8'h3C); send(8'h00);
    chk("rs_vel0_ready", 32'(note_ready_a), 32'(1));
    chk("rs_vel0_note", 32'(note_a), exp_note(1'b0, 7'h3C, 7'h00));
    send(8'h80); send(8'h40); send(8'h20);
    chk("off_ready", 32'(note_ready_a), 32'(1));
    chk("off_note", 32'(note_a), exp_note(1'b0, 7'h40, 7'h20));

    // Channel filtering: channel 1 rejected by dut_a, accepted by the OMNI instance.
    send(8'h91); send(8'h3C); send(8'h64);
    chk("ch1_a_ready", 32'(note_ready_a), 32'(0));
    chk("ch1_omni_ready", 32'(note_ready_b), 32'(1));
    chk("ch1_a_note_held", 32'(note_a), exp_note(1'b0, 7'h40, 7'h20));
    send(8'h90); send(8'h3C); send(8'h64);
    chk("ch0_a_ready", 32'(note_ready_a), 32'(1));
    chk("ch0_omni_ready", 32'(note_ready_b), 32'(1));

    // Back-to-back valid bytes on consecutive cycles.
    @(negedge clk); byte_data = 8'h90; byte_valid = 1'b1;
    @(negedge clk); byte_data = 8'h3E;
    @(negedge clk); byte_data = 8'h70;
    @(negedge clk); byte_valid = 1'b0;
    chk("b2b_ready", 32'(note_ready_a), 32'(1));
    chk("b2b_note", 32'(note_a), exp_note(1'b1, 7'h3E, 7'h70));

    // Real-time byte in the middle of a message is transparent.
    send(8'h90); send(8'h3C); send(8'hF8);
    chk("rt_no_strobe", 32'(note_ready_a), 32'(0));
    send(8'h64);
    chk("rt_ready", 32'(note_ready_a), 32'(1));
    chk("rt_note", 32'(note_a), exp_note(1'b1, 7'h3C, 7'h64));

    // SysEx aborts the message; F7 clears running status.
    idle(1); snap();
    send(8'h90); send(8'h3C); send(8'hF0); send(8'h01); send(8'h02); send(8'hF7);
    send(8'h45);
    idle(2);
    chk("sysex_no_events", 32'(note_cnt_a - snap_a), 32'(0));
    send(8'h3C); send(8'h40);
    idle(2);
    chk("rs_cleared_no_events", 32'(note_cnt_a - snap_a), 32'(0));

    // Control change leaves note untouched; program change is skipped.
    send(8'hB0); send(8'h07); send(8'h7F);
    chk("cc_ready", 32'(cc_ready_a), 32'(1));
    chk("cc_number", 32'(cc_number_a), 32'(7'h07));
    chk("cc_value", 32'(cc_value_a), 32'(7'h7F));
    chk("cc_no_note_ready", 32'(note_ready_a), 32'(0));
    chk("cc_note_unchanged", 32'(note_a), exp_note(1'b1, 7'h3C, 7'h64));
    idle(1); snap();
    send(8'hC0); send(8'h05); send(8'h06);
    idle(2);
    chk("pc_no_note", 32'(note_cnt_a - snap_a), 32'(0));
    chk("pc_no_cc", 32'(cc_cnt_a - snap_cc), 32'(0));

    // Reset mid-message drops the partial note.
    send(8'h90); send(8'h3C);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    snap();
    send(8'h64);
    idle(2);
    chk("rst_mid_no_strobe", 32'(note_cnt_a - snap_a), 32'(0));
    chk("rst_mid_omni_no_strobe", 32'(note_cnt_b - snap_b), 32'(0));
    chk("rst_mid_note", 32'(note_a), exp_note(1'b0, 7'h00, 7'h00));
    chk("rst_mid_cc_number", 32'(cc_number_a), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
